// File: rtl/bcd_seq_conv.sv
// bcd_seq_conv: sequential binary-to-BCD converter (shift-add-3, one bit per clock).
// Accepts a WIDTH-bit operand on start, produces hundreds/tens/ones digits with a
// one-cycle done pulse WIDTH+1 edges after acceptance. Reset (ar) is synchronous,
// active-high.
// Optional build macro BCD_SEQ_CONV_SIGNED_EN: treat binary as two's complement,
// convert the magnitude and report the sign on neg. Without it neg is tied to 0.
module bcd_seq_conv #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             ar,
    input  logic             start,
    input  logic [WIDTH-1:0] binary,
    output logic             busy,
    output logic             done,
    output logic [3:0]       hundreds,
    output logic [3:0]       tens,
    output logic [3:0]       ones,
    output logic             neg
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [11:0]      scratch_q, scratch_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [3:0]       hundreds_q, hundreds_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       ones_q, ones_d;
    logic [WIDTH-1:0] operand;
    logic [11:0]      adj;

    // Add 3 to every BCD nibble that is 5 or more, so the following shift carries correctly.
    function automatic logic [11:0] add3(input logic [11:0] s);
        logic [11:0] r;
        r = s;
        for (int i = 0; i < 3; i++) begin
            if (r[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

`ifdef BCD_SEQ_CONV_SIGNED_EN
    logic sign_q, sign_d;
    logic neg_q, neg_d;

    // Magnitude of the two's-complement operand; WIDTH-bit unsigned, so the most
    // negative value maps to 2**(WIDTH-1) without overflow.
    always_comb begin
        operand = binary[WIDTH-1] ? (WIDTH'(0) - binary) : binary;
    end

    // Sign is captured on acceptance and published together with the digits.
    always_comb begin
        sign_d = sign_q;
        neg_d  = neg_q;
        if (state_q == IDLE && start) begin
            sign_d = binary[WIDTH-1];
        end
        if (state_q == FINISH) begin
            neg_d = sign_q;
        end
    end

    // Sign registers.
    always_ff @(posedge clk) begin
        if (ar) begin
            sign_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            sign_q <= sign_d;
            neg_q  <= neg_d;
        end
    end

    assign neg = neg_q;
`else
    // Unsigned build: operand is used as-is and the sign output is constant.
    always_comb begin
        operand = binary;
    end

    assign neg = 1'b0;
`endif

    // Next-state and datapath: accept, shift WIDTH times, then publish the digits.
    always_comb begin
        // NOTE: every signal gets a default first so no path can leave it unassigned and infer a latch.
        state_d    = state_q;
        shreg_d    = shreg_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        hundreds_d = hundreds_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        adj        = add3(scratch_q);
        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d   = operand;
                    scratch_d = '0;
                    cnt_d     = CW'(WIDTH);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                {scratch_d, shreg_d} = {adj[10:0], shreg_q, 1'b0};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                hundreds_d = scratch_q[11:8];
                tens_d     = scratch_q[7:4];
                ones_d     = scratch_q[3:0];
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (ar) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            hundreds_q <= '0;
            tens_q     <= '0;
            ones_q     <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            hundreds_q <= hundreds_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign hundreds = hundreds_q;
    assign tens     = tens_q;
    assign ones     = ones_q;

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Testbench for bcd_seq_conv: scoreboard of expected results produced by an
// arithmetic reference model, checked by an independent per-cycle monitor.
module tb_bcd_seq_conv;

    localparam int W = 8;

    logic         clk;
    logic         ar;
    logic         start;
    logic [W-1:0] binary;
    logic         busy;
    logic         done;
    logic [3:0]   hundreds;
    logic [3:0]   tens;
    logic [3:0]   ones;
    logic         neg;

    typedef struct {
        int h;
        int t;
        int o;
        int n;
        int done_cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 0;
    int   hold_h = 0;
    int   hold_t = 0;
    int   hold_o = 0;
    int   hold_n = 0;

    bcd_seq_conv #(.WIDTH(W)) dut (
        .clk      (clk),
        .ar       (ar),
        .start    (start),
        .binary   (binary),
        .busy     (busy),
        .done     (done),
        .hundreds (hundreds),
        .tens     (tens),
        .ones     (ones),
        .neg      (neg)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: decimal digits of the (possibly signed) operand value.
    function automatic exp_t model(input logic [W-1:0] v, input int dc);
        exp_t r;
        int   mag;
        int   n;
        mag = int'(v);
        n   = 0;
`ifdef BCD_SEQ_CONV_SIGNED_EN
        if (v[W-1]) begin
            n   = 1;
            mag = (1 << W) - int'(v);
        end
`endif
        r.h        = mag / 100;
        r.t        = (mag / 10) % 10;
        r.o        = mag % 10;
        r.n        = n;
        r.done_cyc = dc;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request that the converter will accept on the next edge.
    task automatic issue(input logic [W-1:0] v);
        start  = 1'b1;
        binary = v;
        tick();
        sb.push_back(model(v, cyc + W + 1));
        start  = 1'b0;
        binary = W'($urandom);
    endtask

    // Full conversion; returns in the done cycle (converter idle).
    task automatic run(input logic [W-1:0] v);
        issue(v);
        repeat (W + 1) tick();
    endtask

    // Conversion with a stray start issued while busy at edge E_k.
    task automatic run_with_junk(input logic [W-1:0] v, input int k, input logic [W-1:0] junk);
        issue(v);
        repeat (k - 1) tick();
        start  = 1'b1;
        binary = junk;
        tick();
        start  = 1'b0;
        repeat (W + 1 - k) tick();
    endtask

    // Monitor: every cycle compare busy/done/digits against the scoreboard.
    initial begin
        exp_t e;
        int   exp_busy;
        wait (mon_en);
        forever begin
            @(negedge clk);
            exp_busy = (sb.size() > 0 && cyc < sb[0].done_cyc) ? 1 : 0;
            check("busy", int'(busy), exp_busy);
            if (sb.size() > 0 && cyc == sb[0].done_cyc) begin
                check("done_pulse", int'(done), 1);
                e      = sb.pop_front();
                hold_h = e.h;
                hold_t = e.t;
                hold_o = e.o;
                hold_n = e.n;
            end else begin
                check("done_idle", int'(done), 0);
            end
            check("hundreds", int'(hundreds), hold_h);
            check("tens", int'(tens), hold_t);
            check("ones", int'(ones), hold_o);
            check("neg", int'(neg), hold_n);
        end
    end

    // Stimulus.
    initial begin
        ar     = 1'b1;
        start  = 1'b0;
        binary = '0;
        repeat (3) tick();
        ar     = 1'b0;
        mon_en = 1'b1;
        tick();

        // Zero, then representative values.
        run(W'(0));
        tick();
        run(W'(255));
        tick();
        run(W'(99));
        run(W'(100));
        tick();

        // Start while busy is ignored.
        run_with_junk(W'(42), 3, W'(200));
        tick();

        // Back-to-back: new request accepted in the done cycle.
        run(W'(17));
        run(W'(250));
        tick();

        // Reset mid-conversion aborts with no done pulse.
        issue(W'(123));
        repeat (3) tick();
        ar = 1'b1;
        tick();
        ar = 1'b0;
        sb.delete();
        hold_h = 0;
        hold_t = 0;
        hold_o = 0;
        hold_n = 0;
        tick();
        run(W'(7));
        tick();

        // Values whose interpretation depends on the signed build.
        run(W'(8'hF6));
        run(W'(8'h80));
        tick();

        // Randomised traffic.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: run(W'($urandom));
                1: run_with_junk(W'($urandom), int'($urandom_range(1, W + 1)), W'($urandom));
                default: begin
                    run(W'($urandom));
                    repeat ($urandom_range(1, 3)) tick();
                end
            endcase
        end

        repeat (3) tick();
        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
